// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and default sizes for the APB master
// Contents: FSM state enum, default address/data widths, default ACCESS wait limit.
package apb_pkg;

  localparam int APB_ADDR_W         = 32;
  localparam int APB_DATA_W         = 32;
  localparam int APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_timer.sv
// rtl/apb_master_timer.sv - clearable saturating wait-cycle counter
// Ports:
//   i_clk   in  1      clock
//   i_rst   in  1      synchronous reset, active-high
//   i_clr   in  1      clear counter to 0 (wins over increment)
//   i_inc   in  1      increment by one, holding at all-ones
//   o_count out CNT_W  current count
module apb_master_timer #(
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB initiator: single-beat command port to APB SETUP/ACCESS transfers
// Optional feature macro: APB_MASTER_TIMEOUT_EN (ACCESS-phase wait limit with error response).
// Ports:
//   pclk, presetn            clock; synchronous active-high reset
//   cmd_valid/ready/write    command handshake and direction
//   cmd_addr, cmd_wdata      command address and write data
//   rsp_valid, rsp_rdata     one-cycle completion pulse with read data
//   rsp_err                  timeout abort flag (0 without the macro)
//   psel, penable, pwrite    APB control
//   paddr, pwdata            APB address and write data
//   pready, prdata           APB slave ready and read data
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  apb_state_e        r_state;
  apb_state_e        w_next_state;
  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_done;
  logic              w_abort;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  assign w_done   = (r_state == ST_ACCESS) && pready;
  assign w_accept = cmd_valid && w_cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] w_wait_cnt;

  // Count holds the number of earlier stalled ACCESS cycles, so the abort
  // fires in the stalled cycle that brings the total to TIMEOUT_CYCLES.
  apb_master_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk   (pclk),
    .i_rst   (presetn),
    .i_clr   (r_state == ST_SETUP),
    .i_inc   ((r_state == ST_ACCESS) && !pready),
    .o_count (w_wait_cnt)
  );

  assign w_abort = (r_state == ST_ACCESS) && !pready &&
                   (w_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_abort = 1'b0;
`endif

  // State register
  always_ff @(posedge pclk) begin
    if (presetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (cmd_valid) w_next_state = ST_SETUP;
      ST_SETUP:  w_next_state = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          // A command taken at completion skips IDLE for back-to-back SETUP
          w_next_state = cmd_valid ? ST_SETUP : ST_IDLE;
        end else if (w_abort) begin
          w_next_state = ST_IDLE;
        end
      end
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    psel        = (r_state != ST_IDLE);
    penable     = (r_state == ST_ACCESS);
    w_cmd_ready = (r_state == ST_IDLE) || w_done;
  end

  // Ready is held low while reset is asserted
  assign cmd_ready = w_cmd_ready && !presetn;

  // Transfer attributes and response registers
  always_ff @(posedge pclk) begin
    if (presetn) begin
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
      r_rsp_valid <= w_done || w_abort;
      r_rsp_err   <= w_abort;
      r_rsp_rdata <= (w_done && !r_pwrite) ? prdata : '0;
    end
  end

  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] mem [0:255];

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (psel && penable && pready && pwrite) mem[paddr[7:0]] <= pwdata;
    end

    assign prdata = mem[paddr[7:0]];

    apb_master dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        presetn   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        pready    = 1'b1;
        step();
        step();

        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_paddr", paddr, 32'h0);
        presetn = 1'b0;
        #1;
        check("idle_cmd_ready", cmd_ready, 1'b1);

        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h5; cmd_wdata = 32'h6;
        step();
        cmd_valid = 1'b0;
        check("wr_setup_psel", psel, 1'b1);
        check("wr_setup_penable", penable, 1'b0);
        check("wr_setup_paddr", paddr, 32'h5);
        check("wr_setup_pwdata", pwdata, 32'h6);
        check("wr_setup_pwrite", pwrite, 1'b1);
        step();
        check("wr_access_penable", penable, 1'b1);
        check("wr_access_rsp_valid", rsp_valid, 1'b0);
        step();
        check("wr_rsp_valid", rsp_valid, 1'b1);
        check("wr_rsp_err", rsp_err, 1'b0);
        check("wr_rsp_rdata", rsp_rdata, 32'h0);
        check("wr_done_psel", psel, 1'b0);
        step();
        check("wr_rsp_pulse_end", rsp_valid, 1'b0);

        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5; cmd_wdata = 32'h0;
        step();
        cmd_valid = 1'b0;
        check("rd_setup_pwrite", pwrite, 1'b0);
        step();
        step();
        check("rd_rsp_valid", rsp_valid, 1'b1);
        check("rd_rsp_rdata", rsp_rdata, 32'h6);

        pready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check("ws_penable", penable, 1'b1);
            check("ws_paddr", paddr, 32'h5);
            check("ws_rsp_valid", rsp_valid, 1'b0);
            step();
        end
        pready = 1'b1;
        check("ws_last_penable", penable, 1'b1);
        step();
        check("ws_rsp_valid_end", rsp_valid, 1'b1);
        check("ws_rsp_rdata", rsp_rdata, 32'h6);
        check("ws_done_psel", psel, 1'b0);

        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hAA;
        step();
        cmd_write = 1'b0; cmd_addr = 32'h10; cmd_wdata = 32'h0;
        check("b2b_setup_cmd_ready", cmd_ready, 1'b0);
        step();
        check("b2b_access_cmd_ready", cmd_ready, 1'b1);
        check("b2b_access_pwrite", pwrite, 1'b1);
        check("b2b_access_pwdata", pwdata, 32'hAA);
        step();
        cmd_valid = 1'b0;
        check("b2b_second_psel", psel, 1'b1);
        check("b2b_second_penable", penable, 1'b0);
        check("b2b_second_pwrite", pwrite, 1'b0);
        check("b2b_first_rsp", rsp_valid, 1'b1);
        step();
        check("b2b_gap_rsp", rsp_valid, 1'b0);
        check("b2b_second_access", penable, 1'b1);
        step();
        check("b2b_second_rsp", rsp_valid, 1'b1);
        check("b2b_second_rdata", rsp_rdata, 32'hAA);

        pready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5;
        step();
        cmd_valid = 1'b0;
        step();
        check("mid_access_penable", penable, 1'b1);
        presetn = 1'b1;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1'b0);
        step();
        check("mid_rst_psel", psel, 1'b0);
        check("mid_rst_penable", penable, 1'b0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        presetn = 1'b0;
        pready  = 1'b1;
        step();
        check("post_rst_rsp_valid", rsp_valid, 1'b0);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

`ifdef APB_MASTER_TIMEOUT_EN
        pready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 15; i++) begin
            check("to_wait_penable", penable, 1'b1);
            step();
        end
        check("to_last_penable", penable, 1'b1);
        check("to_last_rsp_valid", rsp_valid, 1'b0);
        step();
        check("to_abort_psel", psel, 1'b0);
        check("to_abort_rsp_valid", rsp_valid, 1'b1);
        check("to_abort_rsp_err", rsp_err, 1'b1);
        check("to_abort_rsp_rdata", rsp_rdata, 32'h0);
        pready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h7; cmd_wdata = 32'h3;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("to_next_rsp_valid", rsp_valid, 1'b1);
        check("to_next_rsp_err", rsp_err, 1'b0);
`endif

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
